// File: rtl/clint_pkg.sv
// Shared encodings for the CLINT bus initiator: command ops, register offsets,
// sequencer states and the per-step access descriptor.
package clint_pkg;

  localparam logic [1:0] OP_READ_MTIME     = 2'd0;
  localparam logic [1:0] OP_WRITE_MTIMECMP = 2'd1;
  localparam logic [1:0] OP_WRITE_MSIP     = 2'd2;
  localparam logic [1:0] OP_READ_MTIMECMP  = 2'd3;

  localparam logic [31:0] MSIP_OFF        = 32'h0000_0000;
  localparam logic [31:0] MTIMECMP_LO_OFF = 32'h0000_4000;
  localparam logic [31:0] MTIMECMP_HI_OFF = 32'h0000_4004;
  localparam logic [31:0] MTIME_LO_OFF    = 32'h0000_BFF8;
  localparam logic [31:0] MTIME_HI_OFF    = 32'h0000_BFFC;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  typedef struct packed {
    logic        we;
    logic [31:0] off;
    logic [31:0] data;
  } access_t;

  // Which bus access a command performs at a given step of its sequence.
  function automatic access_t access_desc(input logic [1:0]  op,
                                          input logic [1:0]  step,
                                          input logic [63:0] wdata);
    access_t a;
    a.we   = 1'b0;
    a.off  = MSIP_OFF;
    a.data = 32'h0;
    case (op)
      OP_READ_MTIME: begin
        a.off = (step == 2'd1) ? MTIME_LO_OFF : MTIME_HI_OFF;
      end
      OP_WRITE_MTIMECMP: begin
        a.we = 1'b1;
        case (step)
          2'd0: begin
            a.off  = MTIMECMP_LO_OFF;
            a.data = 32'hFFFF_FFFF;
          end
          2'd1: begin
            a.off  = MTIMECMP_HI_OFF;
            a.data = wdata[63:32];
          end
          default: begin
            a.off  = MTIMECMP_LO_OFF;
            a.data = wdata[31:0];
          end
        endcase
      end
      OP_WRITE_MSIP: begin
        a.we   = 1'b1;
        a.off  = MSIP_OFF;
        a.data = {31'b0, wdata[0]};
      end
      default: begin
        a.off = (step == 2'd0) ? MTIMECMP_LO_OFF : MTIMECMP_HI_OFF;
      end
    endcase
    return a;
  endfunction

  function automatic logic [1:0] last_step(input logic [1:0] op);
    logic [1:0] s;
    case (op)
      OP_READ_MTIME:     s = 2'd2;
      OP_WRITE_MTIMECMP: s = 2'd2;
      OP_WRITE_MSIP:     s = 2'd0;
      default:           s = 2'd1;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/clint_bus_access.sv
// Single-access engine: holds the bus pins stable for one access, reports
// completion (with pass-through read data) or abort after a stall timeout.
module clint_bus_access #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic        bus_en_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ready_i
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic          en_q, en_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stall;
  logic          timeout;

  assign stall   = en_q & ~bus_ready_i;
  assign timeout = stall & (cnt_q == TMO_LAST);
  assign done_o  = en_q & (bus_ready_i | timeout);
  assign err_o   = timeout;
  assign rdata_o = bus_rdata_i;

  assign bus_en_o    = en_q;
  assign bus_we_o    = we_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;

  // A request is only taken while idle; the caller spaces requests so that
  // bus_en is low for one cycle between accesses.
  always_comb begin
    en_d    = en_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    if (en_q) begin
      if (bus_ready_i || timeout) en_d = 1'b0;
      if (stall) cnt_d = cnt_q + CW'(1);
    end else if (req_i) begin
      en_d    = 1'b1;
      we_d    = we_i;
      addr_d  = addr_i;
      wdata_d = wdata_i;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      cnt_q   <= '0;
    end else begin
      en_q    <= en_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/clint_bus_master.sv
// Turns 64-bit CLINT commands into 32-bit access sequences: tear-free mtime
// read with retry, glitch-free mtimecmp write, msip write, mtimecmp read.
module clint_bus_master
  import clint_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0200_0000,
  parameter int          TIMEOUT_CYCLES = 16,
  parameter int          MAX_RETRY      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [63:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [63:0] rsp_data,
  output logic        rsp_err,
  output logic        bus_en,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready
);

  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);

  logic [1:0]    state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [1:0]    step_q, step_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [31:0]   h1_q, h1_d;
  logic [31:0]   lo_q, lo_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic [63:0]   rsp_data_q, rsp_data_d;

  logic          acc_req;
  access_t       acc_desc;
  logic          acc_done;
  logic          acc_err;
  logic [31:0]   acc_rdata;
  logic [1:0]    sel_op;
  logic [1:0]    sel_step;
  logic [63:0]   sel_wdata;

  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;

  // The first access is described straight from the command inputs so it
  // issues on the cycle right after acceptance.
  always_comb begin
    if (state_q == S_IDLE) begin
      sel_op    = cmd_op;
      sel_step  = 2'd0;
      sel_wdata = cmd_wdata;
    end else begin
      sel_op    = op_q;
      sel_step  = step_q;
      sel_wdata = wdata_q;
    end
    acc_desc = access_desc(sel_op, sel_step, sel_wdata);
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    wdata_d     = wdata_q;
    step_d      = step_q;
    retry_d     = retry_q;
    h1_d        = h1_q;
    lo_d        = lo_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    acc_req     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          acc_req = 1'b1;
          op_d    = cmd_op;
          wdata_d = cmd_wdata;
          step_d  = 2'd0;
          retry_d = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (acc_done) begin
          if (acc_err) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = 64'h0;
            state_d     = S_RESP;
          end else if (step_q != last_step(op_q)) begin
            if (op_q == OP_READ_MTIME && step_q == 2'd0) h1_d = acc_rdata;
            if ((op_q == OP_READ_MTIME && step_q == 2'd1) || op_q == OP_READ_MTIMECMP)
              lo_d = acc_rdata;
            step_d  = step_q + 2'd1;
            state_d = S_GAP;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_data_d  = 64'h0;
            state_d     = S_RESP;
            if (op_q == OP_READ_MTIMECMP) begin
              rsp_data_d = {acc_rdata, lo_q};
            end else if (op_q == OP_READ_MTIME) begin
              if (acc_rdata == h1_q) begin
                rsp_data_d = {h1_q, lo_q};
              end else if (retry_q == RETRY_LAST) begin
                rsp_err_d  = 1'b1;
                rsp_data_d = {acc_rdata, lo_q};
              end else begin
                // hi rolled over between reads: re-read lo against the new hi
                rsp_valid_d = 1'b0;
                rsp_err_d   = rsp_err_q;
                rsp_data_d  = rsp_data_q;
                h1_d        = acc_rdata;
                retry_d     = retry_q + RW'(1);
                step_d      = 2'd1;
                state_d     = S_GAP;
              end
            end
          end
        end
      end
      S_GAP: begin
        acc_req = 1'b1;
        state_d = S_ISSUE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= 2'd0;
      wdata_q     <= 64'h0;
      step_q      <= 2'd0;
      retry_q     <= '0;
      h1_q        <= 32'h0;
      lo_q        <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= 64'h0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      wdata_q     <= wdata_d;
      step_q      <= step_d;
      retry_q     <= retry_d;
      h1_q        <= h1_d;
      lo_q        <= lo_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  clint_bus_access #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_access (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (acc_req),
    .we_i        (acc_desc.we),
    .addr_i      (BASE_ADDR + acc_desc.off),
    .wdata_i     (acc_desc.data),
    .done_o      (acc_done),
    .err_o       (acc_err),
    .rdata_o     (acc_rdata),
    .bus_en_o    (bus_en),
    .bus_we_o    (bus_we),
    .bus_addr_o  (bus_addr),
    .bus_wdata_o (bus_wdata),
    .bus_rdata_i (bus_rdata),
    .bus_ready_i (bus_ready)
  );

endmodule

// File: doc/clint_bus_master.md
Name: clint_bus_master

Overview:
Bus initiator that drives the CLINT register interface (bus_en/bus_we/bus_addr/bus_wdata/bus_rdata/bus_ready) on behalf of the core or firmware-assist logic. It turns single 64-bit commands into the multi-access 32-bit sequences the CLINT needs:
- tear-free mtime read (hi-lo-hi with retry);
- glitch-free mtimecmp write (lo=all-ones, hi, lo);
- msip write;
- mtimecmp read.

It sits between the core's system-register path and the CLINT slave port.

Parameters:
BASE_ADDR, 32'h0200_0000, CLINT base address.
TIMEOUT_CYCLES, 16, max cycles bus_en may stay high without bus_ready before the access aborts.
MAX_RETRY, 4, max hi-lo-hi re-reads for READ_MTIME before an error response.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high when a command can be accepted (IDLE)
cmd_op  in  2  0=READ_MTIME, 1=WRITE_MTIMECMP, 2=WRITE_MSIP, 3=READ_MTIMECMP
cmd_wdata  in  64  write data (msip uses bit 0)
rsp_valid  out  1  one-cycle completion pulse, no backpressure
rsp_data  out  64  read result; 0 for writes
rsp_err  out  1  qualifies rsp_valid: timeout or retry exhaustion
bus_en  out  1  access request
bus_we  out  1  1=write
bus_addr  out  32  byte address
bus_wdata  out  32  write data
bus_rdata  in  32  read data, valid when bus_ready=1
bus_ready  in  1  access complete

Behaviour:
- Reset values: all outputs 0 except cmd_ready=1. State=IDLE. Reset deasserts bus_en immediately (async); any in-flight command is dropped with no response.
- Address map, as offsets from BASE_ADDR: msip +0x0000, mtimecmp lo +0x4000, mtimecmp hi +0x4004, mtime lo +0xBFF8, mtime hi +0xBFFC.
- Command acceptance: a command is accepted on a posedge where cmd_valid & cmd_ready. The block latches cmd_op and cmd_wdata. cmd_ready=0 until the cycle after rsp_valid.
- Bus handshake:
  - bus_en/bus_we/bus_addr/bus_wdata are registered and held stable while bus_en=1.
  - An access completes on the posedge where bus_en=1 & bus_ready=1. Read data is captured on that edge.
  - bus_en then drops for exactly one GAP cycle before the next access.
  - bus_ready while bus_en=0 is ignored.
- FSM states: IDLE -> ISSUE (bus_en=1, wait ready) -> GAP -> ISSUE ... -> RESP -> IDLE. A step counter selects the access within the sequence.
- RESP: after the final access completes, the GAP slot becomes RESP. rsp_valid=1 for one cycle. With a zero-wait slave, a k-access command pulses rsp_valid 2k cycles after acceptance.
- Sequences:
  - READ_MTIME: read hi (h1), read lo (l), read hi (h2).
    - If h2==h1: rsp_data={h1,l}.
    - Else restart at the lo read with h1:=h2 and increment the retry counter.
    - Retry counter reaching MAX_RETRY gives rsp_err=1, rsp_data={h2,l}.
  - WRITE_MTIMECMP: write lo=32'hFFFF_FFFF, write hi=wdata[63:32], write lo=wdata[31:0].
  - WRITE_MSIP: single write of {31'b0,wdata[0]}.
  - READ_MTIMECMP: read lo, read hi; rsp_data={hi,lo}, no retry.
- Timeout:
  - The counter clears on entry to ISSUE and increments each cycle bus_en=1 & !bus_ready.
  - When it reaches TIMEOUT_CYCLES: bus_en drops next cycle, the remaining accesses are skipped, RESP follows with rsp_err=1 and rsp_data=0.
  - Counter width is clog2(TIMEOUT_CYCLES+1).
- Boundary: bus_ready asserted in the first ISSUE cycle is valid (zero wait). A cmd_valid held during a busy period is not accepted until IDLE.

Decomposition:
- clint_pkg holds:
  - op encodings (OP_READ_MTIME etc.);
  - offsets MSIP_OFF, MTIMECMP_LO_OFF, MTIMECMP_HI_OFF, MTIME_LO_OFF, MTIME_HI_OFF;
  - the state enum.
- Sub-module clint_bus_access is a single-access engine: request/done/err, bus pins, timeout counter, GAP cycle.
- The top contains the sequencing FSM and the retry logic.

Test Plan:
- WRITE_MSIP wdata=1, zero-wait slave -> one write to 0x0200_0000 data 1; rsp_valid 2 cycles after accept, rsp_err=0; CLINT software_irq=1.
- WRITE_MTIMECMP wdata=64'h0000_0001_0000_0020 -> writes in order: (0x0200_4000, FFFF_FFFF), (0x0200_4004, 0000_0001), (0x0200_4000, 0000_0020); bus_en low 1 cycle between each.
- READ_MTIME with slave returning hi=5, lo=0x10, hi=5 -> rsp_data=64'h0000_0005_0000_0010, rsp_err=0, exactly 3 accesses.
- READ_MTIME with hi changing 5->6 on the first pass, then stable -> 5 accesses; rsp_data={6, second lo}; rsp_err=0. Also: hi changes on every read -> rsp_err=1 after MAX_RETRY=4.
- Slave never asserts bus_ready on READ_MTIMECMP -> bus_en high exactly 16 cycles, then low; rsp_err=1, rsp_data=0; cmd_ready=1 the following cycle.
- rst_n low mid-WRITE_MTIMECMP (after the first access) -> bus_en=0 asynchronously, no rsp_valid; cmd_ready=1 after release and a fresh command executes normally.
